// File: rtl/saradc_11b_dig_sar_seq_if.sv
// Request/result handshake bundle between the SAR sequencer (slave) and its client (master).
interface saradc_11b_dig_sar_seq_if #(
  parameter int unsigned N_CHANNELS = 16,
  parameter int unsigned SAR_MSB    = 12
) ();
  localparam int unsigned CHW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  logic             req_valid_i;
  logic             req_ready_o;
  logic [CHW-1:0]   req_ch_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [SAR_MSB:0] res_data_o;
  logic [CHW-1:0]   res_ch_o;
  logic             res_err_o;

  modport master (
    output req_valid_i, req_ch_i, res_ready_i,
    input  req_ready_o, res_valid_o, res_data_o, res_ch_o, res_err_o
  );

  modport slave (
    input  req_valid_i, req_ch_i, res_ready_i,
    output req_ready_o, res_valid_o, res_data_o, res_ch_o, res_err_o
  );
endinterface

// File: rtl/saradc_11b_dig_sar_seq.sv
// SAR ADC conversion sequencer: sample phase, bit-serial SAR search, result handshake.
// Optional abort of an in-flight conversion with `define SARADC_11B_SEQ_ABORT_EN.
module saradc_11b_dig_sar_seq #(
  parameter int unsigned N_CHANNELS = 16,
  parameter int unsigned SAR_MSB    = 12,
  parameter int unsigned SAMPLE_CYC = 8
) (
  input  logic                  clk_i,
  input  logic                  res_i,
  saradc_11b_dig_sar_seq_if.slave bus,
  output logic [N_CHANNELS-1:0] sample_ch_o,
  output logic                  sar_res_o,
  output logic                  comp_res_o,
  output logic                  sar_clk_o,
  output logic [SAR_MSB:0]      dac_o,
  input  logic                  comp_i
`ifdef SARADC_11B_SEQ_ABORT_EN
  ,
  input  logic                  abort_i
`endif
);

  localparam int unsigned CHW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int unsigned W   = SAR_MSB + 1;
  localparam int unsigned BW  = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned CW  = $clog2(SAMPLE_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONV, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            phase_q, phase_d;
  logic [W-1:0]    code_q, code_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic            err_q, err_d;

  logic                  req_ready_q, req_ready_d;
  logic                  sar_res_q, sar_res_d;
  logic                  comp_res_q, comp_res_d;
  logic                  sar_clk_q, sar_clk_d;
  logic [N_CHANNELS-1:0] sample_ch_q, sample_ch_d;
  logic [W-1:0]          dac_q, dac_d;
  logic                  res_valid_q, res_valid_d;
  logic [W-1:0]          res_data_q, res_data_d;
  logic [CHW-1:0]        res_ch_q, res_ch_d;
  logic                  res_err_q, res_err_d;

  logic abort_c;
`ifdef SARADC_11B_SEQ_ABORT_EN
  assign abort_c = abort_i;
`else
  assign abort_c = 1'b0;
`endif

  // State, datapath and output registers
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      code_q      <= '0;
      ch_q        <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      sar_res_q   <= 1'b1;
      comp_res_q  <= 1'b1;
      sar_clk_q   <= 1'b0;
      sample_ch_q <= '0;
      dac_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      code_q      <= code_d;
      ch_q        <= ch_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      sar_res_q   <= sar_res_d;
      comp_res_q  <= comp_res_d;
      sar_clk_q   <= sar_clk_d;
      sample_ch_q <= sample_ch_d;
      dac_q       <= dac_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
      res_err_q   <= res_err_d;
    end
  end

  // Next state: phase A presents the trial code, phase B's closing edge captures comp_i
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    code_d  = code_q;
    ch_d    = ch_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i && req_ready_q) begin
          state_d = S_SAMPLE;
          ch_d    = bus.req_ch_i;
          err_d   = (32'(bus.req_ch_i) >= N_CHANNELS);
          cnt_d   = '0;
          code_d  = '0;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == CW'(SAMPLE_CYC - 1)) begin
          state_d = S_CONV;
          bit_d   = BW'(SAR_MSB);
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CONV: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (comp_i) code_d = code_q | (W'(1) << bit_q);
          if (bit_q == '0) state_d = S_DONE;
          else             bit_d   = bit_q - BW'(1);
        end
      end
      S_DONE: begin
        if (bus.res_ready_i && res_valid_q) state_d = S_IDLE;
      end
    endcase
    if (abort_c && ((state_q == S_SAMPLE) || (state_q == S_CONV))) state_d = S_IDLE;
  end

  // Output decode from the upcoming state so every port comes straight from a flop
  always_comb begin
    req_ready_d = 1'b0;
    sar_res_d   = 1'b0;
    comp_res_d  = 1'b0;
    sar_clk_d   = 1'b0;
    sample_ch_d = '0;
    dac_d       = '0;
    res_valid_d = 1'b0;
    res_data_d  = '0;
    res_ch_d    = '0;
    res_err_d   = 1'b0;
    unique case (state_d)
      S_IDLE: begin
        req_ready_d = 1'b1;
        sar_res_d   = 1'b1;
        comp_res_d  = 1'b1;
      end
      S_SAMPLE: begin
        sar_res_d   = 1'b1;
        comp_res_d  = 1'b1;
        sample_ch_d = err_d ? '0 : (N_CHANNELS'(1) << ch_d);
      end
      S_CONV: begin
        sar_clk_d = phase_d;
        dac_d     = code_d | (W'(1) << bit_d);
      end
      S_DONE: begin
        res_valid_d = 1'b1;
        res_data_d  = code_d;
        res_ch_d    = ch_d;
        res_err_d   = err_d;
      end
    endcase
  end

  assign bus.req_ready_o = req_ready_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_data_o  = res_data_q;
  assign bus.res_ch_o    = res_ch_q;
  assign bus.res_err_o   = res_err_q;
  assign sample_ch_o     = sample_ch_q;
  assign sar_res_o       = sar_res_q;
  assign comp_res_o      = comp_res_q;
  assign sar_clk_o       = sar_clk_q;
  assign dac_o           = dac_q;

endmodule

// File: tb/tb_saradc_11b_dig_sar_seq.sv
// Self-checking bench: ideal comparator model around the sequencer, randomized conversions.
module tb_saradc_11b_dig_sar_seq;
  localparam int unsigned SAR_MSB    = 12;
  localparam int unsigned SAMPLE_CYC = 8;
  localparam int unsigned CONV_CYC   = 2 * (SAR_MSB + 1);

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default 16 channels
  saradc_11b_dig_sar_seq_if #(.N_CHANNELS(16), .SAR_MSB(SAR_MSB)) bus_a ();
  logic [15:0]      sample_ch_a;
  logic             sar_res_a, comp_res_a, sar_clk_a;
  logic [SAR_MSB:0] dac_a;
  logic             comp_a;
`ifdef SARADC_11B_SEQ_ABORT_EN
  logic             abort_a = 1'b0;
`endif

  // Instance B: 12 channels, used for the out-of-range channel case
  saradc_11b_dig_sar_seq_if #(.N_CHANNELS(12), .SAR_MSB(SAR_MSB)) bus_b ();
  logic [11:0]      sample_ch_b;
  logic             sar_res_b, comp_res_b, sar_clk_b;
  logic [SAR_MSB:0] dac_b;
`ifdef SARADC_11B_SEQ_ABORT_EN
  logic             abort_b = 1'b0;
`endif

  // Analog input model: 0 = ideal comparator against ana_v, 1 = tied high, 2 = tied low
  logic [SAR_MSB:0] ana_v = '0;
  int               comp_mode = 0;
  always_comb begin
    comp_a = 1'b0;
    case (comp_mode)
      0:       comp_a = (ana_v >= dac_a);
      1:       comp_a = 1'b1;
      default: comp_a = 1'b0;
    endcase
  end

  saradc_11b_dig_sar_seq #(.N_CHANNELS(16), .SAR_MSB(SAR_MSB), .SAMPLE_CYC(SAMPLE_CYC)) u_dut_a (
    .clk_i(clk), .res_i(res), .bus(bus_a.slave),
    .sample_ch_o(sample_ch_a), .sar_res_o(sar_res_a), .comp_res_o(comp_res_a),
    .sar_clk_o(sar_clk_a), .dac_o(dac_a), .comp_i(comp_a)
`ifdef SARADC_11B_SEQ_ABORT_EN
    , .abort_i(abort_a)
`endif
  );

  saradc_11b_dig_sar_seq #(.N_CHANNELS(12), .SAR_MSB(SAR_MSB), .SAMPLE_CYC(SAMPLE_CYC)) u_dut_b (
    .clk_i(clk), .res_i(res), .bus(bus_b.slave),
    .sample_ch_o(sample_ch_b), .sar_res_o(sar_res_b), .comp_res_o(comp_res_b),
    .sar_clk_o(sar_clk_b), .dac_o(dac_b), .comp_i(1'b1)
`ifdef SARADC_11B_SEQ_ABORT_EN
    , .abort_i(abort_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_req_ready"}, 32'(bus_a.req_ready_o), 1);
    chk({tag, "_sar_res"},   32'(sar_res_a), 1);
    chk({tag, "_comp_res"},  32'(comp_res_a), 1);
    chk({tag, "_sar_clk"},   32'(sar_clk_a), 0);
    chk({tag, "_sample_ch"}, 32'(sample_ch_a), 0);
    chk({tag, "_dac"},       32'(dac_a), 0);
    chk({tag, "_res_valid"}, 32'(bus_a.res_valid_o), 0);
    chk({tag, "_res_data"},  32'(bus_a.res_data_o), 0);
    chk({tag, "_res_ch"},    32'(bus_a.res_ch_o), 0);
    chk({tag, "_res_err"},   32'(bus_a.res_err_o), 0);
  endtask

  // Full conversion on instance A; exp_code is what the comparator model must resolve to
  task automatic run_conv(input int ch, input int exp_code, input int stall, input bit keep_valid);
    int n;
    int kept;
    int edac;
    n = 0;
    while (!bus_a.req_ready_o && n < 100) begin
      tick();
      n++;
    end
    chk("req_ready_before_req", 32'(bus_a.req_ready_o), 1);
    bus_a.res_ready_i = 1'b0;
    bus_a.req_valid_i = 1'b1;
    bus_a.req_ch_i    = 4'(ch);
    tick();
    if (!keep_valid) bus_a.req_valid_i = 1'b0;
    for (int c = 1; c <= int'(SAMPLE_CYC); c++) begin
      chk("sample_ch", 32'(sample_ch_a), 32'(1) << ch);
      chk("sample_sar_res", 32'(sar_res_a), 1);
      chk("sample_comp_res", 32'(comp_res_a), 1);
      chk("sample_req_ready", 32'(bus_a.req_ready_o), 0);
      chk("sample_res_valid", 32'(bus_a.res_valid_o), 0);
      tick();
    end
    for (int k = int'(SAR_MSB); k >= 0; k--) begin
      kept = (exp_code >> (k + 1)) << (k + 1);
      edac = kept | (1 << k);
      chk("convA_sar_clk", 32'(sar_clk_a), 0);
      chk("convA_dac", 32'(dac_a), 32'(edac));
      chk("conv_sample_ch", 32'(sample_ch_a), 0);
      chk("conv_resets", {30'd0, sar_res_a, comp_res_a}, 0);
      tick();
      chk("convB_sar_clk", 32'(sar_clk_a), 1);
      chk("convB_dac", 32'(dac_a), 32'(edac));
      chk("convB_res_valid", 32'(bus_a.res_valid_o), 0);
      tick();
    end
    // Now in cycle SAMPLE_CYC + CONV_CYC + 1
    chk("done_res_valid", 32'(bus_a.res_valid_o), 1);
    chk("done_res_data", 32'(bus_a.res_data_o), 32'(exp_code));
    chk("done_res_ch", 32'(bus_a.res_ch_o), 32'(ch));
    chk("done_res_err", 32'(bus_a.res_err_o), 0);
    chk("done_req_ready", 32'(bus_a.req_ready_o), 0);
    for (int s = 0; s < stall; s++) begin
`ifdef SARADC_11B_SEQ_ABORT_EN
      abort_a = (s == 0);
`endif
      tick();
`ifdef SARADC_11B_SEQ_ABORT_EN
      abort_a = 1'b0;
`endif
      chk("stall_res_valid", 32'(bus_a.res_valid_o), 1);
      chk("stall_res_data", 32'(bus_a.res_data_o), 32'(exp_code));
      chk("stall_res_ch", 32'(bus_a.res_ch_o), 32'(ch));
      chk("stall_req_ready", 32'(bus_a.req_ready_o), 0);
    end
    bus_a.res_ready_i = 1'b1;
    tick();
    bus_a.res_ready_i = 1'b0;
    chk("post_consume_res_valid", 32'(bus_a.res_valid_o), 0);
    chk("post_consume_req_ready", 32'(bus_a.req_ready_o), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ch;
    int v;
    bus_a.req_valid_i = 1'b0;
    bus_a.req_ch_i    = '0;
    bus_a.res_ready_i = 1'b0;
    bus_b.req_valid_i = 1'b0;
    bus_b.req_ch_i    = '0;
    bus_b.res_ready_i = 1'b0;

    res = 1'b1;
    repeat (3) tick();
    chk_reset_a("rst");
    res = 1'b0;
    tick();
    chk_reset_a("idle");

    // Directed: channel 5, analog value 0x0A5A
    ana_v = 13'h0A5A;
    comp_mode = 0;
    run_conv(5, 'h0A5A, 0, 1'b0);

    // Comparator tied high / low
    comp_mode = 1;
    run_conv(3, 'h1FFF, 1, 1'b0);
    comp_mode = 2;
    run_conv(0, 'h0000, 0, 1'b0);

    // Long stall with request held high; next request lands one cycle after consumption
    comp_mode = 0;
    ana_v = 13'h1234;
    run_conv(15, 'h1234, 20, 1'b1);
    ana_v = 13'h0777;
    run_conv(9, 'h0777, 0, 1'b0);

    // Out-of-range channel on the 12-channel instance
    bus_b.req_valid_i = 1'b1;
    bus_b.req_ch_i    = 4'd14;
    tick();
    bus_b.req_valid_i = 1'b0;
    for (int c = 1; c <= int'(SAMPLE_CYC + CONV_CYC); c++) begin
      chk("err_sample_ch", 32'(sample_ch_b), 0);
      chk("err_res_valid_early", 32'(bus_b.res_valid_o), 0);
      tick();
    end
    chk("err_res_valid", 32'(bus_b.res_valid_o), 1);
    chk("err_res_err", 32'(bus_b.res_err_o), 1);
    chk("err_res_ch", 32'(bus_b.res_ch_o), 14);
    chk("err_res_data", 32'(bus_b.res_data_o), 'h1FFF);
    bus_b.res_ready_i = 1'b1;
    tick();
    bus_b.res_ready_i = 1'b0;
    chk("err_post_req_ready", 32'(bus_b.req_ready_o), 1);

    // Reset in the middle of CONV
    ana_v = 13'h0F0F;
    bus_a.req_valid_i = 1'b1;
    bus_a.req_ch_i    = 4'd7;
    tick();
    bus_a.req_valid_i = 1'b0;
    repeat (SAMPLE_CYC + 19) tick();
    res = 1'b1;
    tick();
    res = 1'b0;
    chk_reset_a("midrst");
    for (int c = 0; c < 40; c++) begin
      chk("midrst_no_result", 32'(bus_a.res_valid_o), 0);
      tick();
    end
    run_conv(7, 'h0F0F, 0, 1'b0);

`ifdef SARADC_11B_SEQ_ABORT_EN
    // Abort in cycle 3 of SAMPLE
    bus_a.req_valid_i = 1'b1;
    bus_a.req_ch_i    = 4'd2;
    tick();
    bus_a.req_valid_i = 1'b0;
    tick();
    tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk_reset_a("abort");
    for (int c = 0; c < 40; c++) begin
      chk("abort_no_result", 32'(bus_a.res_valid_o), 0);
      tick();
    end
`endif

    // Randomized conversions
    for (int i = 0; i < 8; i++) begin
      ch = int'($urandom_range(15, 0));
      v  = int'($urandom_range(8191, 0));
      ana_v = 13'(v);
      comp_mode = 0;
      run_conv(ch, v, int'($urandom_range(3, 0)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/saradc_11b_dig_sar_seq.md
# saradc_11b_dig_sar_seq

Successive-approximation conversion sequencer for the 11-bit SAR ADC digital core. It accepts a channel conversion request and drives the one-hot sample switch and the sample/reset strobes. It then steps the SAR trial code bit by bit against the analog comparator and returns the result with its channel tag through a valid/ready handshake. It sits directly upstream of the analog ADC interface, drives its sampling/SAR controls and consumes its comparator output.

## Interface
- N_CHANNELS, 16, number of analog input channels
- SAR_MSB, 12, MSB index of SAR code (code width SAR_MSB+1)
- SAMPLE_CYC, 8, sampling-phase length in clocks (≥1)
- CHW (localparam), $clog2(N_CHANNELS), channel index width

Ports:
- clk_i  in  1  core clock, all logic on rising edge
- res_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  conversion request
- req_ready_o  out  1  sequencer idle, request accepted on valid&ready
- req_ch_i  in  CHW  channel to convert
- sample_ch_o  out  N_CHANNELS  one-hot sample switch
- sar_res_o  out  1  SAR/DAC reset
- comp_res_o  out  1  comparator reset
- sar_clk_o  out  1  comparator strobe
- dac_o  out  SAR_MSB+1  trial code to capacitive DAC
- comp_i  in  1  comparator result, 1 = input ≥ DAC level
- res_valid_o  out  1  result available
- res_ready_i  in  1  consumer takes result
- res_data_o  out  SAR_MSB+1  conversion result
- res_ch_o  out  CHW  channel tag of result
- res_err_o  out  1  requested channel ≥ N_CHANNELS
- abort_i  in  1  only with SARADC_11B_SEQ_ABORT_EN

## Operation
- States: IDLE, SAMPLE, CONV, DONE.
- IDLE: req_ready_o=1, sar_res_o=1, comp_res_o=1, sample_ch_o=0, dac_o=0. On req_valid_i&req_ready_o: latch req_ch_i, set err flag if req_ch_i ≥ N_CHANNELS, go to SAMPLE.
- SAMPLE: SAMPLE_CYC clocks; sample_ch_o[ch]=1 (all zero if err); sar_res_o=1, comp_res_o=1. After the last cycle go to CONV with bit index k=SAR_MSB.
- CONV: two clocks per bit.
  - Phase A: sar_clk_o=0; dac_o = kept bits | (1<<k).
  - Phase B: sar_clk_o=1; comp_i is sampled on the closing edge. If it is 1, bit k is kept, else it is cleared.
  - After bit 0 go to DONE.
  - sar_res_o=0, comp_res_o=0 and sample_ch_o=0 throughout CONV.
- DONE: res_valid_o=1, with res_data_o/res_ch_o/res_err_o stable. On res_ready_i go to IDLE. req_ready_o=0.
- Arithmetic: code register SAR_MSB+1 bits, no overflow possible. All-ones comp gives 2^(SAR_MSB+1)-1; all-zeros comp gives 0.
- req_valid_i outside IDLE is ignored (not queued).

## Timing
- Reset values: req_ready_o=1, sar_res_o=1, comp_res_o=1, sar_clk_o=0, sample_ch_o=0, dac_o=0, res_valid_o=0, res_data_o=0, res_ch_o=0, res_err_o=0. State is IDLE.
- Handshake edge = cycle 0. SAMPLE occupies cycles 1..SAMPLE_CYC. CONV occupies the next 2·(SAR_MSB+1) cycles. res_valid_o rises in cycle SAMPLE_CYC+2·(SAR_MSB+1)+1; with defaults that is cycle 35.
- A result is consumed on the edge where res_valid_o&res_ready_i. req_ready_o=1 the next cycle, so a new request can be accepted one cycle after consumption.
- res_ready_i held low: stall in DONE indefinitely, outputs held.
- res_i asserted in any state: on the next edge, all outputs go to reset values and the in-flight conversion is lost. res_i wins over any simultaneous handshake.
- All outputs are registered; comp_i is not used combinationally.

## Configuration
- SARADC_11B_SEQ_ABORT_EN defined:
  - abort_i port present.
  - abort_i=1 in SAMPLE or CONV: next edge enters IDLE with reset-value outputs and no result.
  - abort_i in IDLE or DONE is ignored.
- Macro undefined: no abort_i port; a conversion always runs to DONE.

## Test plan
- Request ch 5; comparator model of analog value 0x0A5A -> sample_ch_o=0x0020 for 8 cycles, res_valid_o at cycle 35, res_data_o=0x0A5A, res_ch_o=5, res_err_o=0.
- comp_i tied 1, then tied 0 -> res_data_o=0x1FFF, then 0x0000. In the first CONV phase A, dac_o=0x1000.
- res_ready_i low for 20 cycles with req_valid_i held high -> res_valid_o and data stable, req_ready_o=0. After ready, the next request is accepted one cycle later.
- N_CHANNELS=12, request ch 14 -> sample_ch_o stays 0, conversion runs, res_err_o=1, res_ch_o=14.
- res_i pulsed at cycle 20 of CONV -> all outputs at reset values the next cycle, no res_valid_o; a following request converts normally.
- With SARADC_11B_SEQ_ABORT_EN, abort_i at cycle 3 of SAMPLE -> IDLE next cycle, sample_ch_o=0, no result. abort_i during DONE -> no effect.
